axi4_lite_register_bank: RTL and testbench
==========================================

// Module: axi4_lite_register_bank
// PURPOSE
//  AXI4-Lite slave register bank, 2**MW registers of N*8 bits. Direct FSM handshakes, no channel FIFOs.
//  Per-register access mode (RW / RO / W1C), byte strobes, SLVERR on illegal access, write/read strobes.
//  Sits between the AXI4-Lite interconnect and core control/status logic.
// PARAMETERS
//  A        32  address width (>= 32)
//  N        4   data width in bytes (4 or 8)
//  MW       3   register index width; MI = 2**MW registers
//  RO_MASK  0   MI bits; bit j=1 -> reg j read-only (reads reg_in[j])
//  W1C_MASK 0   MI bits; bit j=1 -> reg j write-1-to-clear, set by hw_set[j] (ignored if RO)
//  RST_VAL  0   N*8-bit reset value of every RW/W1C register
// PORTS
//  aclk      in   1       clock
//  areset    in   1       synchronous reset, active high
//  awaddr    in   A       write address
//  awvalid   in   1       / awready out 1
//  wdata     in   N*8     write data
//  wstrb     in   N       byte strobes
//  wvalid    in   1       / wready out 1
//  bresp     out  2       00 OKAY, 10 SLVERR
//  bvalid    out  1       / bready in 1
//  araddr    in   A       read address
//  arvalid   in   1       / arready out 1
//  rdata     out  N*8     read data
//  rresp     out  2       00 OKAY, 10 SLVERR
//  rvalid    out  1       / rready in 1
//  reg_out   out  MI*N*8  register contents, reg j at [j*N*8 +: N*8]
//  reg_in    in   MI*N*8  hw values returned for RO registers
//  hw_set    in   MI*N*8  hw set bits for W1C registers
//  wr_pulse  out  MI      1-cycle pulse, reg j successfully written
//  rd_pulse  out  MI      1-cycle pulse, reg j successfully read (AR handshake)
// BEHAVIOUR
//  Index idx = addr[LB+MW-1:LB], LB = 2 (N=4) or 3 (N=8); addr bits [LB-1:0] ignored.
//  Illegal address: any of addr[A-1:LB+MW] nonzero -> SLVERR, no side effects.
//  Reset: all handshake outputs/valids 0, bresp=rresp=00, rdata=0, pulses 0, RW/W1C regs = RST_VAL.
//  Write FSM W_ADDR_DATA -> W_RESP:
//   awready=1 while AW not yet latched and in W_ADDR_DATA; wready likewise for W. AW and W accepted
//   independently, any order or same cycle. Cycle after both latched: commit, wr_pulse, enter W_RESP
//   with bvalid=1. bvalid held until bready; then back to W_ADDR_DATA. No new AW/W in W_RESP.
//  Write commit: RW -> byte j replaced where wstrb[j]=1. W1C -> bit cleared where wdata=1 in a strobed byte.
//   RO -> SLVERR, nothing changed, no wr_pulse. wstrb=0 on RW/W1C -> OKAY, value unchanged, wr_pulse fires.
//  W1C: every cycle reg |= hw_set; same-cycle set and clear of a bit -> set wins.
//  Read FSM R_IDLE -> R_RESP: arready=1 in R_IDLE only. AR handshake captures rdata (RW/W1C: reg_out,
//   RO: reg_in, illegal: 0) and rresp, pulses rd_pulse (legal only); rvalid=1 next cycle, rdata/rresp
//   stable until rready, then R_IDLE. Latency AR->rvalid = 1 cycle; W commit->bvalid = 1 cycle.
//  Read and write FSMs independent; read same cycle as a commit to the same reg returns the OLD value.
//  areset mid-transaction: both FSMs to idle, valids drop immediately, pending response is lost.
// TESTING
//  RW reg 1 = 0, write 0x1122_3344 to 0x04 wstrb=0011 -> bresp 00, reg_out[1]=0x0000_3344, wr_pulse[1].
//  W before AW by 3 cycles, bready low 4 cycles -> single commit, bvalid held 4 cycles, wready low meanwhile.
//  W1C reg 2: hw_set=0x0F, write 0x05 strb 0001 -> reads 0x0A; write 0x02 with hw_set=0x02 same cycle -> bit 1 stays 1.
//  Write RO reg 3 -> bresp 10, no pulse; read reg 3 with reg_in[3]=0xCAFE -> rdata 0xCAFE, rresp 00, rd_pulse[3].
//  Read araddr=0x1000 (MW=3) -> rresp 10, rdata 0; write there -> bresp 10, no reg change.
//  areset asserted while rvalid=1 and rready=0 -> rvalid 0 next cycle, all regs RST_VAL, arready 1.

Source files
------------

// File: rtl/axi4_lite_register_bank_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_register_bank_if
// AXI4-Lite bus bundle between an interconnect master and the register bank.
//   AW : awaddr, awvalid / awready
//   W  : wdata, wstrb, wvalid / wready
//   B  : bresp, bvalid / bready
//   AR : araddr, arvalid / arready
//   R  : rdata, rresp, rvalid / rready
// Parameters: A = address width, N = data width in bytes.
// ---------------------------------------------------------------------------
interface axi4_lite_register_bank_if #(
    parameter int A = 32,
    parameter int N = 4
);
    logic [A-1:0]   awaddr;
    logic           awvalid;
    logic           awready;
    logic [N*8-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [A-1:0]   araddr;
    logic           arvalid;
    logic           arready;
    logic [N*8-1:0] rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_register_bank.sv
// ---------------------------------------------------------------------------
// axi4_lite_register_bank
// AXI4-Lite slave holding 2**MW registers of N*8 bits each. Every register is
// RW, RO (returns reg_in) or W1C (set by hw_set, cleared by writing ones).
// Ports:
//   aclk, areset  clock, synchronous active-high reset
//   s_axi         AXI4-Lite slave bus (AW/W/B/AR/R channels)
//   reg_out       register contents, reg j at [j*N*8 +: N*8] (RO regs show reg_in)
//   reg_in        hardware values returned for RO registers
//   hw_set        per-bit set requests for W1C registers
//   wr_pulse      one-cycle pulse per successfully written register
//   rd_pulse      one-cycle pulse per successfully read register
// ---------------------------------------------------------------------------
module axi4_lite_register_bank #(
    parameter int                    A        = 32,
    parameter int                    N        = 4,
    parameter int                    MW       = 3,
    parameter logic [(2**MW)-1:0]    RO_MASK  = '0,
    parameter logic [(2**MW)-1:0]    W1C_MASK = '0,
    parameter logic [N*8-1:0]        RST_VAL  = '0
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi4_lite_register_bank_if.slave     s_axi,
    output logic [(2**MW)*N*8-1:0]       reg_out,
    input  logic [(2**MW)*N*8-1:0]       reg_in,
    input  logic [(2**MW)*N*8-1:0]       hw_set,
    output logic [(2**MW)-1:0]           wr_pulse,
    output logic [(2**MW)-1:0]           rd_pulse
);
    localparam int MI = 2**MW;
    localparam int D  = N*8;
    localparam int LB = (N == 8) ? 3 : 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic { W_ADDR_DATA, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_RESP }      rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    logic [MI-1:0][D-1:0] regs_q;
    logic [MI-1:0][D-1:0] reg_view;
    logic [MI-1:0][D-1:0] reg_in_a;
    logic [MI-1:0][D-1:0] hw_set_a;

    assign reg_in_a = reg_in;
    assign hw_set_a = hw_set;

    // RO registers have no storage of their own; they mirror reg_in.
    always_comb begin
        for (int j = 0; j < MI; j++)
            reg_view[j] = RO_MASK[j] ? reg_in_a[j] : regs_q[j];
    end
    assign reg_out = reg_view;

    // ---------------- write side ----------------
    logic          aw_held, w_held;
    logic [MW-1:0] aw_idx;
    logic          aw_err;
    logic [D-1:0]  w_data;
    logic [N-1:0]  w_strb;
    logic [D-1:0]  bmask;
    logic          aw_hs, w_hs, commit, w_legal, w_ok;

    assign aw_hs   = s_axi.awvalid && s_axi.awready;
    assign w_hs    = s_axi.wvalid  && s_axi.wready;
    // Commit happens in the first cycle where both halves are latched.
    assign commit  = (wstate == W_ADDR_DATA) && aw_held && w_held;
    assign w_legal = !aw_err && !RO_MASK[aw_idx];
    assign w_ok    = commit && w_legal;

    always_comb begin
        for (int b = 0; b < N; b++)
            bmask[b*8 +: 8] = {8{w_strb[b]}};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            regs_q <= {MI{RST_VAL}};
        end else begin
            for (int j = 0; j < MI; j++) begin
                if (!RO_MASK[j]) begin
                    if (W1C_MASK[j]) begin
                        // Clear first, then OR in hw_set so a same-cycle set wins.
                        regs_q[j] <= (regs_q[j] & ~((w_ok && aw_idx == MW'(j)) ? (w_data & bmask) : '0))
                                     | hw_set_a[j];
                    end else if (w_ok && aw_idx == MW'(j)) begin
                        regs_q[j] <= (regs_q[j] & ~bmask) | (w_data & bmask);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate        <= W_ADDR_DATA;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            aw_err        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            wr_pulse      <= '0;
        end else begin
            wr_pulse <= '0;
            case (wstate)
                W_ADDR_DATA: begin
                    if (commit) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                        s_axi.bvalid  <= 1'b1;
                        s_axi.bresp   <= w_legal ? OKAY : SLVERR;
                        wr_pulse      <= w_legal ? (MI'(1) << aw_idx) : '0;
                        wstate        <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held <= 1'b1;
                            aw_idx  <= s_axi.awaddr[LB +: MW];
                            aw_err  <= |s_axi.awaddr[A-1:LB+MW];
                        end
                        if (w_hs) begin
                            w_held <= 1'b1;
                            w_data <= s_axi.wdata;
                            w_strb <= s_axi.wstrb;
                        end
                        s_axi.awready <= !(aw_held || aw_hs);
                        s_axi.wready  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        wstate        <= W_ADDR_DATA;
                    end
                end
                default: wstate <= W_ADDR_DATA;
            endcase
        end
    end

    // ---------------- read side ----------------
    logic [MW-1:0] ar_idx;
    logic          ar_err;

    assign ar_idx = s_axi.araddr[LB +: MW];
    assign ar_err = |s_axi.araddr[A-1:LB+MW];

    // Data is captured from the pre-update view, so a read colliding with a
    // write commit to the same register returns the old value.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate        <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= '0;
            case (rstate)
                R_IDLE: begin
                    if (s_axi.arvalid && s_axi.arready) begin
                        s_axi.arready <= 1'b0;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.rdata   <= ar_err ? '0 : reg_view[ar_idx];
                        s_axi.rresp   <= ar_err ? SLVERR : OKAY;
                        rd_pulse      <= ar_err ? '0 : (MI'(1) << ar_idx);
                        rstate        <= R_RESP;
                    end else begin
                        s_axi.arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_register_bank.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_register_bank
// Directed and random AXI4-Lite traffic against a register-array model.
// Config: 8 x 32-bit registers, reg 3 read-only, reg 2 write-1-to-clear.
// ---------------------------------------------------------------------------
module tb_axi4_lite_register_bank;
    localparam int A  = 32;
    localparam int N  = 4;
    localparam int MW = 3;
    localparam int MI = 8;
    localparam logic [7:0]  RO_M  = 8'b0000_1000;
    localparam logic [7:0]  W1C_M = 8'b0000_0100;
    localparam logic [31:0] RSTV  = 32'h0;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic [MI*32-1:0] reg_out;
    logic [MI*32-1:0] reg_in;
    logic [MI*32-1:0] hw_set;
    logic [MI-1:0]    wr_pulse, rd_pulse;

    axi4_lite_register_bank_if #(.A(A), .N(N)) bus ();

    axi4_lite_register_bank #(
        .A(A), .N(N), .MW(MW), .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RST_VAL(RSTV)
    ) dut (
        .aclk(aclk), .areset(areset), .s_axi(bus.slave),
        .reg_out(reg_out), .reg_in(reg_in), .hw_set(hw_set),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mdl [MI];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mdl_flat();
        logic [255:0] f;
        for (int j = 0; j < MI; j++) f[j*32 +: 32] = mdl[j];
        return f;
    endfunction

    // Reference: what a write should do, from the register-map rules.
    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [31:0] cset, output logic [1:0] eresp, output logic [7:0] epulse);
        int  idx;
        bit  illegal;
        idx     = int'(addr[4:2]);
        illegal = (addr >> 5) != 0;
        if (illegal || idx == 3) begin
            eresp  = 2'b10;
            epulse = 8'h00;
        end else begin
            eresp  = 2'b00;
            epulse = 8'(1 << idx);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    if (idx == 2) mdl[2][b*8 +: 8] = mdl[2][b*8 +: 8] & ~data[b*8 +: 8];
                    else          mdl[idx][b*8 +: 8] = data[b*8 +: 8];
                end
            end
        end
        mdl[2] = mdl[2] | cset;
    endtask

    task automatic mdl_read(input logic [31:0] addr, output logic [31:0] edata,
                            output logic [1:0] eresp, output logic [7:0] epulse);
        if ((addr >> 5) != 0) begin
            edata = 32'h0; eresp = 2'b10; epulse = 8'h00;
        end else begin
            edata = mdl[addr[4:2]]; eresp = 2'b00; epulse = 8'(1 << addr[4:2]);
        end
    endtask

    // AW issued aw_lead cycles after start, W after w_lead; bready held low
    // for b_hold cycles of bvalid; cset is driven on hw_set[2] in the commit cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_lead, input int w_lead, input int b_hold, input logic [31:0] cset,
                            output logic [1:0] resp, output logic [7:0] pulse);
        bit aw_sent = 0, w_sent = 0, aw_done = 0, w_done = 0, aw_go, w_go;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.bready = 1'b0;
        for (int c = 0; c < 64 && !(aw_done && w_done); c++) begin
            if (c >= aw_lead && !aw_sent) begin bus.awvalid = 1'b1; aw_sent = 1; end
            if (c >= w_lead  && !w_sent)  begin bus.wvalid  = 1'b1; w_sent  = 1; end
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid  && bus.wready;
            @(negedge aclk);
            if (aw_go) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            if (w_done && !aw_done) chk("wready_low_after_w", 256'(bus.wready), 256'(0));
            if (aw_done && !w_done) chk("awready_low_after_aw", 256'(bus.awready), 256'(0));
        end
        chk("aw_w_handshake", 256'(aw_done && w_done), 256'(1));
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        hw_set[2*32 +: 32] = cset;
        @(negedge aclk);
        hw_set[2*32 +: 32] = 32'h0;
        chk("bvalid_latency", 256'(bus.bvalid), 256'(1));
        resp  = bus.bresp;
        pulse = wr_pulse;
        for (int h = 0; h < b_hold; h++) begin
            @(negedge aclk);
            chk("bvalid_held", 256'(bus.bvalid), 256'(1));
            chk("ready_low_in_resp", 256'({bus.awready, bus.wready}), 256'(0));
            chk("wr_pulse_single", 256'(wr_pulse), 256'(0));
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        chk("bvalid_drop", 256'(bus.bvalid), 256'(0));
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic [7:0] pulse);
        bit go, done = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            go = bus.arready;
            @(negedge aclk);
            if (go) begin bus.arvalid = 1'b0; done = 1; end
        end
        chk("ar_handshake", 256'(done), 256'(1));
        bus.arvalid = 1'b0;
        chk("rvalid_latency", 256'(bus.rvalid), 256'(1));
        data = bus.rdata; resp = bus.rresp; pulse = rd_pulse;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        chk("rvalid_drop", 256'(bus.rvalid), 256'(0));
    endtask

    initial begin
        logic [1:0]  resp, eresp;
        logic [7:0]  pulse, epulse;
        logic [31:0] data, edata, addr, wd;
        logic [3:0]  strb;
        bit          ok;

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        hw_set = '0;
        for (int j = 0; j < MI; j++) reg_in[j*32 +: 32] = $urandom;
        reg_in[3*32 +: 32] = 32'h0000_CAFE;
        for (int j = 0; j < MI; j++) mdl[j] = RSTV;
        mdl[3] = 32'h0000_CAFE;

        // reset state
        repeat (3) @(negedge aclk);
        chk("rst_readies", 256'({bus.awready, bus.wready, bus.arready}), 256'(0));
        chk("rst_valids", 256'({bus.bvalid, bus.rvalid}), 256'(0));
        chk("rst_resp_data", 256'({bus.bresp, bus.rresp, bus.rdata}), 256'(0));
        chk("rst_pulses", 256'({wr_pulse, rd_pulse}), 256'(0));
        chk("rst_reg_out", reg_out, mdl_flat());
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_readies", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));

        // partial-strobe write to RW reg 1
        do_write(32'h04, 32'h1122_3344, 4'b0011, 0, 0, 0, 32'h0, resp, pulse);
        mdl_write(32'h04, 32'h1122_3344, 4'b0011, 32'h0, eresp, epulse);
        chk("rw_strb_bresp", 256'(resp), 256'(eresp));
        chk("rw_strb_pulse", 256'(pulse), 256'(8'h02));
        chk("rw_strb_reg1", 256'(reg_out[1*32 +: 32]), 256'(32'h0000_3344));

        // W three cycles ahead of AW, bready low four cycles
        wd = $urandom;
        do_write(32'h00, wd, 4'hF, 3, 0, 4, 32'h0, resp, pulse);
        mdl_write(32'h00, wd, 4'hF, 32'h0, eresp, epulse);
        chk("w_first_bresp", 256'(resp), 256'(eresp));
        chk("w_first_pulse", 256'(pulse), 256'(epulse));
        chk("w_first_regs", reg_out, mdl_flat());

        // W1C register 2
        hw_set[2*32 +: 32] = 32'h0F;
        @(negedge aclk);
        hw_set[2*32 +: 32] = 32'h0;
        mdl[2] = mdl[2] | 32'h0F;
        chk("w1c_hw_set", 256'(reg_out[2*32 +: 32]), 256'(32'h0F));
        do_write(32'h08, 32'h05, 4'b0001, 0, 0, 0, 32'h0, resp, pulse);
        mdl_write(32'h08, 32'h05, 4'b0001, 32'h0, eresp, epulse);
        do_read(32'h08, data, resp, pulse);
        chk("w1c_clear_read", 256'(data), 256'(32'h0A));
        do_write(32'h08, 32'h02, 4'b0001, 0, 0, 0, 32'h02, resp, pulse);
        mdl_write(32'h08, 32'h02, 4'b0001, 32'h02, eresp, epulse);
        chk("w1c_set_wins", 256'(reg_out[2*32 +: 32]), 256'(32'h0A));
        do_write(32'h08, 32'h02, 4'b0001, 0, 0, 0, 32'h0, resp, pulse);
        mdl_write(32'h08, 32'h02, 4'b0001, 32'h0, eresp, epulse);
        chk("w1c_clear_bit1", 256'(reg_out[2*32 +: 32]), 256'(32'h08));

        // RO register 3
        do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'h0, resp, pulse);
        chk("ro_write_bresp", 256'(resp), 256'(2'b10));
        chk("ro_write_pulse", 256'(pulse), 256'(0));
        do_read(32'h0C, data, resp, pulse);
        chk("ro_read", 256'({data, resp, pulse}), 256'({32'h0000_CAFE, 2'b00, 8'h08}));

        // out-of-range address
        do_read(32'h1000, data, resp, pulse);
        chk("illegal_read", 256'({data, resp, pulse}), 256'({32'h0, 2'b10, 8'h00}));
        do_write(32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, resp, pulse);
        chk("illegal_write", 256'({resp, pulse}), 256'({2'b10, 8'h00}));
        chk("illegal_no_change", reg_out, mdl_flat());

        // random traffic
        for (int i = 0; i < 60; i++) begin
            addr = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 5) == 0) addr = addr | (32'h1 << $urandom_range(5, 31));
            if ($urandom_range(0, 1) == 0) begin
                wd   = $urandom;
                strb = 4'($urandom);
                do_write(addr, wd, strb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                         32'h0, resp, pulse);
                mdl_write(addr, wd, strb, 32'h0, eresp, epulse);
                chk("rnd_bresp", 256'(resp), 256'(eresp));
                chk("rnd_wr_pulse", 256'(pulse), 256'(epulse));
                chk("rnd_reg_out", reg_out, mdl_flat());
            end else begin
                do_read(addr, data, resp, pulse);
                mdl_read(addr, edata, eresp, epulse);
                chk("rnd_read", 256'({data, resp, pulse}), 256'({edata, eresp, epulse}));
            end
        end

        // reset while a read response is pending
        bus.araddr = 32'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
        ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin
            ok = bus.arready;
            @(negedge aclk);
        end
        bus.arvalid = 1'b0;
        chk("pre_rst_rvalid", 256'(bus.rvalid), 256'(1));
        areset = 1'b1;
        @(negedge aclk);
        for (int j = 0; j < MI; j++) if (j != 3) mdl[j] = RSTV;
        chk("mid_rst_rvalid", 256'(bus.rvalid), 256'(0));
        chk("mid_rst_regs", reg_out, mdl_flat());
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_arready", 256'(bus.arready), 256'(1));
        do_read(32'h04, data, resp, pulse);
        chk("post_rst_read", 256'({data, resp}), 256'({RSTV, 2'b00}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
